router_pkt_tx: RTL
==================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter ERR_WIN, default 3, meaning the number of cycles after the parity byte during which err_in is sampled.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ld_en  input  1  write ld_data into the payload buffer.
REQ-005 SHALL have port ld_data  input  8  payload byte to load.
REQ-006 SHALL have port ld_count  output  6  number of bytes currently loaded.
REQ-007 SHALL have port ld_full  output  1  high when ld_count equals 63.
REQ-008 SHALL have port start  input  1  request transmission of the loaded packet.
REQ-009 SHALL have port dest  input  2  destination address, sampled on an accepted start.
REQ-010 SHALL have port inj_err  input  1  corrupt the parity byte, sampled on an accepted start.
REQ-011 SHALL have port busy_in  input  1  router busy; a presented byte is consumed only on an edge where busy_in=0.
REQ-012 SHALL have port err_in  input  1  router parity-error flag.
REQ-013 SHALL have port pkt_valid  output  1  high while header and payload bytes are presented.
REQ-014 SHALL have port data_out  output  8  byte presented to the router.
REQ-015 SHALL have port tx_active  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at packet completion.
REQ-017 SHALL have port tx_err  output  1  valid only with done; 1 when err_in was seen in the check window.

Function
REQ-018 SHALL implement the states IDLE, HDR, PAY, PAR and CHK.
REQ-019 SHALL write ld_data and increment ld_count in IDLE when ld_en=1 and ld_full=0; ld_en SHALL be ignored otherwise.
REQ-020 SHALL accept start only in IDLE with ld_count>=1 and dest!=2'b11; other starts SHALL be ignored with no output change.
REQ-021 SHALL drop a load that coincides with an accepted start.
REQ-022 SHALL present, in HDR, pkt_valid=1 and data_out={ld_count,dest}, from the cycle after start is accepted.
REQ-023 SHALL hold data_out and pkt_valid stable while busy_in=1 in any presenting state.
REQ-024 SHALL move HDR->PAY on an edge with busy_in=0.
REQ-025 SHALL present buffer bytes in load order in PAY, advancing one byte per edge with busy_in=0.
REQ-026 SHALL move to PAR after the last payload byte is consumed.
REQ-027 SHALL drive, in PAR, pkt_valid=0 and data_out = XOR of the header and all payload bytes, further XORed with 8'h01 when the latched inj_err=1.
REQ-028 SHALL move PAR->CHK on an edge with busy_in=0.
REQ-029 SHALL remain in CHK for exactly ERR_WIN cycles, accumulating a sticky OR of err_in.
REQ-030 SHALL, at the end of CHK, pulse done=1 for one cycle with tx_err equal to the sticky OR, clear ld_count to 0 and return to IDLE.
REQ-031 SHALL, with busy_in held at 0, reach done in 1+N+1+ERR_WIN cycles after start acceptance for an N-byte payload.
REQ-032 SHALL compute parity as a running register updated as each byte is consumed.

Reset
REQ-033 SHALL on reset, at any time, immediately force: state IDLE, pkt_valid 0, data_out 0, tx_active 0, done 0, tx_err 0, ld_count 0, ld_full 0, parity 0.
REQ-034 SHALL abandon a packet interrupted by reset, with no done pulse.

Structure
REQ-035 SHALL place the state enum, MAX_LEN=63, ADDR_INVALID=2'b11 and the header field widths (length 6, address 2) in package router_tx_pkg.
REQ-036 SHALL implement the payload storage as sub-module router_tx_buf: 63x8, with write pointer/count and an indexed read port, cleared by reset or a clear strobe.

Verification
REQ-037 SHALL cover: load 11,22,33; start dest=1; busy_in=0 -> data_out 0D,11,22,33 with pkt_valid=1; then 0D with pkt_valid=0; done 3 cycles later with tx_err=0.
REQ-038 SHALL cover: same packet with busy_in=1 for 2 cycles while 22 is presented -> 22 held for 3 cycles, no skipped or duplicated byte.
REQ-039 SHALL cover: inj_err=1 and err_in pulsed 2 cycles after parity -> parity byte 0C; done with tx_err=1.
REQ-040 SHALL cover: load 64 bytes -> ld_full=1 after 63, 64th ignored; header FD for dest=1.
REQ-041 SHALL cover: start with dest=3, or start with ld_count=0 -> ignored; tx_active and pkt_valid stay 0.
REQ-042 SHALL cover: reset asserted mid-PAY -> pkt_valid=0 and ld_count=0 before the next edge; no done pulse.

Source files
------------

// File: rtl/router_tx_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_tx_pkg;
    localparam int          MAX_LEN      = 63;
    localparam int          LEN_W        = 6;
    localparam int          ADDR_W       = 2;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, CHK} tx_state_t;
endpackage

// File: rtl/router_pkt_tx_if.sv
// Load, start and router-side signals of the packet transmitter.
interface router_pkt_tx_if;
    logic                              ld_en;
    logic [7:0]                        ld_data;
    logic [router_tx_pkg::LEN_W-1:0]   ld_count;
    logic                              ld_full;
    logic                              start;
    logic [router_tx_pkg::ADDR_W-1:0]  dest;
    logic                              inj_err;
    logic                              busy_in;
    logic                              err_in;
    logic                              pkt_valid;
    logic [7:0]                        data_out;
    logic                              tx_active;
    logic                              done;
    logic                              tx_err;

    modport master (
        input  ld_en, ld_data, start, dest, inj_err, busy_in, err_in,
        output ld_count, ld_full, pkt_valid, data_out, tx_active, done, tx_err
    );
    modport slave (
        output ld_en, ld_data, start, dest, inj_err, busy_in, err_in,
        input  ld_count, ld_full, pkt_valid, data_out, tx_active, done, tx_err
    );
endinterface

// File: rtl/router_tx_buf.sv
// 63x8 payload store: append-only write port, indexed combinational read port.
module router_tx_buf
    import router_tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic [LEN_W-1:0] count,
    output logic             full
);
    logic [7:0] mem [MAX_LEN];

    assign full    = (count == LEN_W'(MAX_LEN));
    // Reads past the end return 0 so the look-ahead address after the last byte is harmless.
    assign rd_data = (rd_addr < LEN_W'(MAX_LEN)) ? mem[rd_addr] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                count <= '0;
        else if (clr)             count <= '0;
        else if (wr_en && !full)  count <= count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full && !clr) mem[count] <= wr_data;
    end
endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: header {len,dest}, payload, parity, then an err_in check window.
module router_pkt_tx
    import router_tx_pkg::*;
#(
    parameter int ERR_WIN = 3
) (
    input  logic             clk,
    input  logic             reset,
    router_pkt_tx_if.master  bus
);
    localparam int CW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;

    tx_state_t        state;
    logic [LEN_W-1:0] pay_idx;
    logic [LEN_W-1:0] count;
    logic [7:0]       rd_data;
    logic [7:0]       parity;
    logic [7:0]       data_q;
    logic             valid_q, done_q, tx_err_q;
    logic             inj_q, err_sticky;
    logic [CW-1:0]    chk_cnt;
    logic             accept, consume, chk_last, wr_en;
    logic [LEN_W-1:0] rd_addr;
    logic [7:0]       par_next;

    assign accept   = (state == IDLE) && bus.start && (count != '0) && (bus.dest != ADDR_INVALID);
    assign consume  = !bus.busy_in;
    assign chk_last = (state == CHK) && (chk_cnt == CW'(ERR_WIN - 1));
    assign wr_en    = (state == IDLE) && bus.ld_en && !accept;
    // Look-ahead: the byte that will be presented after the current one is consumed.
    assign rd_addr  = (state == HDR) ? '0 : pay_idx + 1'b1;
    assign par_next = parity ^ data_q;

    router_tx_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (chk_last),
        .wr_en   (wr_en),
        .wr_data (bus.ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .count   (count),
        .full    (bus.ld_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pay_idx    <= '0;
            parity     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            tx_err_q   <= 1'b0;
            inj_q      <= 1'b0;
            err_sticky <= 1'b0;
            chk_cnt    <= '0;
        end else begin
            done_q   <= 1'b0;
            tx_err_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state   <= HDR;
                    valid_q <= 1'b1;
                    data_q  <= {count, bus.dest};
                    parity  <= '0;
                    inj_q   <= bus.inj_err;
                    pay_idx <= '0;
                end
                HDR: if (consume) begin
                    parity <= par_next;
                    data_q <= rd_data;
                    state  <= PAY;
                end
                PAY: if (consume) begin
                    parity <= par_next;
                    if (pay_idx == count - 1'b1) begin
                        state   <= PAR;
                        valid_q <= 1'b0;
                        data_q  <= par_next ^ {7'b0, inj_q};
                    end else begin
                        pay_idx <= pay_idx + 1'b1;
                        data_q  <= rd_data;
                    end
                end
                PAR: if (consume) begin
                    state      <= CHK;
                    data_q     <= '0;
                    chk_cnt    <= '0;
                    err_sticky <= 1'b0;
                end
                CHK: begin
                    err_sticky <= err_sticky | bus.err_in;
                    if (chk_last) begin
                        done_q   <= 1'b1;
                        tx_err_q <= err_sticky | bus.err_in;
                        state    <= IDLE;
                    end else begin
                        chk_cnt <= chk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ld_count  = count;
    assign bus.pkt_valid = valid_q;
    assign bus.data_out  = data_q;
    assign bus.tx_active = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.tx_err    = tx_err_q;
endmodule
